// File: rtl/top_pkg.sv
// Shared constants, duty types and the hue-to-RGB colour wheel
// for the RGB fader.
package top_pkg;

  localparam int HUE_MAX   = 1535;
  localparam int PWM_BITS  = 8;
  localparam int SEG_COUNT = 6;
  localparam int HUE_BITS  = 11;

  typedef logic [PWM_BITS-1:0] duty_t;

  typedef struct packed {
    duty_t r;
    duty_t g;
    duty_t b;
  } rgb_duty_t;

  // Six 256-step segments; 255-frac is simply ~frac.
  function automatic rgb_duty_t hue_to_rgb(
    input logic [HUE_BITS-1:0] hue
  );
    rgb_duty_t d;
    logic [2:0] seg;
    duty_t      f;
    seg = hue[10:8];
    f   = hue[7:0];
    d   = '0;
    case (seg)
      3'd0: d = '{r: 8'hff, g: f,     b: 8'h00};
      3'd1: d = '{r: ~f,    g: 8'hff, b: 8'h00};
      3'd2: d = '{r: 8'h00, g: 8'hff, b: f    };
      3'd3: d = '{r: 8'h00, g: ~f,    b: 8'hff};
      3'd4: d = '{r: f,     g: 8'h00, b: 8'hff};
      3'd5: d = '{r: 8'hff, g: 8'h00, b: ~f   };
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/top_pwm_channel.sv
// One PWM colour channel: duty register loaded at counter wrap,
// compare, active-low registered pin.
module pwm_channel
  import top_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  duty_t               i_duty,
  input  logic [PWM_BITS-1:0] i_cnt,
  output logic                o_pin
);

  duty_t r_duty = '0;
  logic  r_pin  = 1'b1;
  logic  w_on;

  assign w_on  = (i_cnt < r_duty);
  assign o_pin = r_pin;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_duty <= '0;
      r_pin  <= 1'b1;
    end else begin
      if (i_load) r_duty <= i_duty;
      r_pin <= ~w_on;
    end
  end

endmodule

// File: rtl/top.sv
// RGB colour-wheel fader with a 1 Hz status blink.
// Hue steps around the wheel; three PWM channels drive the LED.
module top
  import top_pkg::*;
#(
  parameter int CLK_HZ    = 12_000_000,
  parameter int STEP_DIV  = 7812,
  parameter int BLINK_DIV = 6_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic LED,
  output logic RGB_R,
  output logic RGB_G,
  output logic RGB_B
);

  localparam int SW = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  if (STEP_DIV < 1 || BLINK_DIV < 1 || CLK_HZ < 1) begin : g_bad_param
    $error("top: CLK_HZ and dividers must be positive");
  end

  logic [SW-1:0]       r_step    = '0;
  logic [BW-1:0]       r_blink   = '0;
  logic [HUE_BITS-1:0] r_hue     = '0;
  logic [PWM_BITS-1:0] r_pwm_cnt = '0;
  logic                r_led     = 1'b0;

  logic      w_step_tick;
  logic      w_blink_tick;
  logic      w_wrap;
  rgb_duty_t w_target;

  assign w_step_tick  = (r_step == SW'(STEP_DIV - 1));
  assign w_blink_tick = (r_blink == BW'(BLINK_DIV - 1));
  assign w_wrap       = (r_pwm_cnt == '1);
  // Built from the current hue, so a coincident step loads the old one.
  assign w_target     = hue_to_rgb(r_hue);
  assign LED          = r_led;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step    <= '0;
      r_blink   <= '0;
      r_hue     <= '0;
      r_pwm_cnt <= '0;
      r_led     <= 1'b0;
    end else begin
      r_step    <= w_step_tick ? '0 : r_step + 1'b1;
      r_blink   <= w_blink_tick ? '0 : r_blink + 1'b1;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_blink_tick) r_led <= ~r_led;
      if (w_step_tick) begin
        r_hue <= (r_hue == HUE_BITS'(HUE_MAX)) ? '0 : r_hue + 1'b1;
      end
    end
  end

  pwm_channel u_r (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_wrap),
    .i_duty (w_target.r),
    .i_cnt  (r_pwm_cnt),
    .o_pin  (RGB_R)
  );

  pwm_channel u_g (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_wrap),
    .i_duty (w_target.g),
    .i_cnt  (r_pwm_cnt),
    .o_pin  (RGB_G)
  );

  pwm_channel u_b (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_wrap),
    .i_duty (w_target.b),
    .i_cnt  (r_pwm_cnt),
    .o_pin  (RGB_B)
  );

endmodule

// File: tb/tb_top.sv
// Bench for the RGB fader: per-cycle scoreboard of LED/RGB pins
// plus a table of per-period low counts and a few sequences.
module tb_top;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic LED, RGB_R, RGB_G, RGB_B;

  always #5 clk = ~clk;

  top #(
    .CLK_HZ   (12_000_000),
    .STEP_DIV (4),
    .BLINK_DIV(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .LED  (LED),
    .RGB_R(RGB_R),
    .RGB_G(RGB_G),
    .RGB_B(RGB_B)
  );

  typedef struct {
    int p;
    int r;
    int g;
    int b;
  } vec_t;

  vec_t       tbl[12];
  int         total = 0;
  int         bad   = 0;
  int         n     = 0;
  int         lowr  = 0;
  int         lowg  = 0;
  int         lowb  = 0;
  logic [3:0] sbq[$];
  int         toggles[$];
  logic       last_led = 1'b0;

  function automatic int duty(int h, int ch);
    int s, f, r, g, b;
    s = h / 256;
    f = h % 256;
    r = 0; g = 0; b = 0;
    case (s)
      0: begin r = 255;     g = f;       b = 0;       end
      1: begin r = 255 - f; g = 255;     b = 0;       end
      2: begin r = 0;       g = 255;     b = f;       end
      3: begin r = 0;       g = 255 - f; b = 255;     end
      4: begin r = f;       g = 0;       b = 255;     end
      5: begin r = 255;     g = 0;       b = 255 - f; end
      default: begin r = 0; g = 0; b = 0; end
    endcase
    if (ch == 0) return r;
    if (ch == 1) return g;
    return b;
  endfunction

  // Expected {LED,R,G,B} in state k (k edges after reset release).
  function automatic logic [3:0] exp_out(int k);
    logic [3:0] e;
    int c, q, h;
    e[3] = ((k / 10) % 2) == 1;
    e[2:0] = 3'b111;
    if (k > 256) begin
      c = (k - 1) % 256;
      q = (k - 1) / 256 - 1;
      h = ((255 + 256 * q) / 4) % 1536;
      e[2] = !(c < duty(h, 0));
      e[1] = !(c < duty(h, 1));
      e[0] = !(c < duty(h, 2));
    end
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] e;
    @(posedge clk);
    if (reset) n = 0;
    else n++;
    sbq.push_back(exp_out(n));
    @(negedge clk);
    e = sbq.pop_front();
    check($sformatf("out@%0d", n), int'({LED, RGB_R, RGB_G, RGB_B}),
          int'(e));
    if (n >= 257) begin
      if ((n - 1) % 256 == 0) begin
        lowr = 0; lowg = 0; lowb = 0;
      end
      lowr += int'(!RGB_R);
      lowg += int'(!RGB_G);
      lowb += int'(!RGB_B);
    end
    if (LED != last_led) toggles.push_back(n);
    last_led = LED;
    if (!reset && n == 6143) begin
      check("hue_1535", int'(dut.r_hue), 1535);
      check("tick_at_1535", int'(dut.w_step_tick), 1);
    end
    if (!reset && n == 6144) check("hue_wrap", int'(dut.r_hue), 0);
  endtask

  initial begin
    tbl[0]  = '{p: 0,  r: 255, g: 63,  b: 0  };
    tbl[1]  = '{p: 1,  r: 255, g: 127, b: 0  };
    tbl[2]  = '{p: 2,  r: 255, g: 191, b: 0  };
    tbl[3]  = '{p: 3,  r: 255, g: 255, b: 0  };
    tbl[4]  = '{p: 4,  r: 192, g: 255, b: 0  };
    tbl[5]  = '{p: 5,  r: 128, g: 255, b: 0  };
    tbl[6]  = '{p: 7,  r: 0,   g: 255, b: 0  };
    tbl[7]  = '{p: 8,  r: 0,   g: 255, b: 63 };
    tbl[8]  = '{p: 12, r: 0,   g: 192, b: 255};
    tbl[9]  = '{p: 16, r: 63,  g: 0,   b: 255};
    tbl[10] = '{p: 20, r: 255, g: 0,   b: 192};
    tbl[11] = '{p: 23, r: 255, g: 0,   b: 0  };

    reset = 1'b1;
    tick();
    tick();
    check("rst_hue", int'(dut.r_hue), 0);
    reset = 1'b0;
    last_led = LED;
    toggles.delete();

    while (n < 256) tick();
    check("coinc_hue_after", int'(dut.r_hue), 64);
    check("coinc_duty_r", int'(dut.u_r.r_duty), 255);
    check("coinc_duty_g", int'(dut.u_g.r_duty), 63);
    check("coinc_duty_b", int'(dut.u_b.r_duty), 0);

    for (int i = 0; i < 12; i++) begin
      while (n < 256 * (tbl[i].p + 2)) tick();
      check($sformatf("lowR_p%0d", tbl[i].p), lowr, tbl[i].r);
      check($sformatf("lowG_p%0d", tbl[i].p), lowg, tbl[i].g);
      check($sformatf("lowB_p%0d", tbl[i].p), lowb, tbl[i].b);
    end

    reset = 1'b1;
    tick();
    check("midrst_hue", int'(dut.r_hue), 0);
    check("midrst_duty_r", int'(dut.u_r.r_duty), 0);
    tick();
    tick();
    reset = 1'b0;
    last_led = LED;
    toggles.delete();
    repeat (35) tick();
    check("led_toggle_cnt", toggles.size(), 3);
    if (toggles.size() == 3) begin
      check("led_toggle0", toggles[0], 10);
      check("led_toggle1", toggles[1], 20);
      check("led_toggle2", toggles[2], 30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter CLK_HZ, default 12_000_000, nominal clock frequency (documentation only).
REQ-002 Parameter STEP_DIV, default 7812, clock cycles per hue step (about 1 s per full color wheel).
REQ-003 Parameter BLINK_DIV, default 6_000_000, clock cycles per LED toggle (1 Hz blink).
REQ-004 Port clk, input, 1, single system clock, rising-edge active.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port LED, output, 1, status blink, active-high.
REQ-007 Port RGB_R, output, 1, red PWM drive, active-low (0 = lit).
REQ-008 Port RGB_G, output, 1, green PWM drive, active-low.
REQ-009 Port RGB_B, output, 1, blue PWM drive, active-low.

Function
REQ-010 Step prescaler shall count 0..STEP_DIV-1 and wrap to 0; step_tick shall be 1 in the cycle the count equals STEP_DIV-1.
REQ-011 Hue register (11 bits) shall increment on step_tick and wrap 1535 -> 0; seg = hue/256 (0..5), frac = hue mod 256.
REQ-012 Target duties (8 bits each) by seg:
- 0: R=255, G=frac, B=0
- 1: R=255-frac, G=255, B=0
- 2: R=0, G=255, B=frac
- 3: R=0, G=255-frac, B=255
- 4: R=frac, G=0, B=255
- 5: R=255, G=0, B=255-frac
REQ-013 The 8-bit PWM counter shall free-run 0..255 and wrap, incrementing every clock.
REQ-014 Duty registers shall load the target duties only in the cycle the PWM counter equals 255; they shall hold at all other times (glitch-free update).
REQ-015 Channel on = (pwm_cnt < duty), compared combinationally against the registered counter; duty 0 = never on, duty 255 = on 255 of 256 cycles.
REQ-016 RGB pin = NOT channel on, driven from a registered output; output latency is 1 clock after the counter value.
REQ-017 Blink prescaler shall count 0..BLINK_DIV-1; LED shall toggle in the cycle the count equals BLINK_DIV-1.
REQ-018 If a step_tick and a PWM wrap occur in the same cycle, the duty load shall use the pre-increment hue; the new hue takes effect at the next wrap.

Reset
REQ-019 reset asserted at a rising edge shall set: both prescalers 0, hue 0, pwm_cnt 0, all duties 0, LED 0, RGB_R/G/B 1 (off).
REQ-020 Reset has priority over all counting; assertion mid-cycle of the wheel shall restart from hue 0 on the next edge.
REQ-021 All registers shall carry the same values as FPGA initial values, so the design runs with reset tied low.

Structure
REQ-022 A shared package shall hold HUE_MAX (1535), PWM_BITS (8), SEG_COUNT (6), and the duty typedef.
REQ-023 One sub-module, pwm_channel (duty load, compare, active-low registered output), shall be instantiated three times.

Verification
REQ-024 Use STEP_DIV=4 and BLINK_DIV=10; release reset, then check RGB all 1 and LED 0 for the first 256+1 cycles (duties 0).
REQ-025 Hold reset 3 cycles after run-up: all outputs return to reset values on the next edge and hue reads 0.
REQ-026 Run to hue=128 (seg 0): over one 256-cycle PWM period, RGB_R is low 255 cycles, RGB_G low 128, RGB_B low 0.
REQ-027 Run to hue=1535, then take one step_tick: hue wraps to 0 and the next period's duties are R=255, G=0, B=0.
REQ-028 LED toggles exactly at cycles 10, 20, 30 after reset release.
REQ-029 Force step_tick coincident with pwm_cnt=255: loaded duties match the pre-increment hue.
